// File: rtl/instr_mem_loader_pkg.sv
// rtl/instr_mem_loader_pkg.sv - shared states and constants for the instruction memory loader
package instr_mem_loader_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOAD = 2'd1,
      ST_RUN  = 2'd2
   } state_e;

   localparam logic [31:0] INSTR_NOP = 32'h0;

   localparam logic [5:0] OP_ADDI = 6'b001000;
   localparam logic [5:0] OP_SB   = 6'b101000;
   localparam logic [5:0] OP_LB   = 6'b100000;
   localparam logic [5:0] FN_SLLV = 6'b000100;

endpackage

// File: rtl/instr_mem_loader_if.sv
// rtl/instr_mem_loader_if.sv - fetch and program-load bundle between datapath/host and loader
interface instr_mem_loader_if #(
   parameter int ADDR_WIDTH = 8,
   parameter int DATA_WIDTH = 32
);
   logic [ADDR_WIDTH-1:0] fetchAddr;
   logic                  fetchEn;
   logic                  loadStart;
   logic                  loadByteValid;
   logic [7:0]            loadByte;
   logic                  loadDone;
   logic [DATA_WIDTH-1:0] instruction;
   logic                  instrValid;
   logic                  loadBusy;
   logic [ADDR_WIDTH:0]   wordCount;
   logic                  overflowErr;
   logic                  partialErr;

   modport master (
      output fetchAddr, fetchEn, loadStart, loadByteValid, loadByte, loadDone,
      input  instruction, instrValid, loadBusy, wordCount, overflowErr, partialErr
   );

   modport slave (
      input  fetchAddr, fetchEn, loadStart, loadByteValid, loadByte, loadDone,
      output instruction, instrValid, loadBusy, wordCount, overflowErr, partialErr
   );
endinterface

// File: rtl/instr_word_assembler.sv
// rtl/instr_word_assembler.sv - packs an MSB-first byte stream into 32-bit words
module instr_word_assembler (
   input  logic        clock,
   input  logic        resetGral,
   input  logic        clear,
   input  logic        byte_valid,
   input  logic [7:0]  byte_in,
   output logic [31:0] word_out,
   output logic        word_done,
   output logic        pending
);
   // Only the three oldest bytes need storing; the fourth comes straight from byte_in.
   logic [23:0] shift_q, shift_d;
   logic [1:0]  cnt_q, cnt_d;

   assign word_out  = {shift_q, byte_in};
   assign word_done = byte_valid && (cnt_q == 2'd3);
   assign pending   = byte_valid ? (cnt_q != 2'd3) : (cnt_q != 2'd0);

   always_comb begin
      shift_d = shift_q;
      cnt_d   = cnt_q;
      if (byte_valid) begin
         shift_d = {shift_q[15:0], byte_in};
         cnt_d   = cnt_q + 2'd1;
      end
      if (clear) begin
         shift_d = '0;
         cnt_d   = '0;
      end
   end

   always_ff @(posedge clock or posedge resetGral) begin
      if (resetGral) begin
         shift_q <= '0;
         cnt_q   <= '0;
      end else begin
         shift_q <= shift_d;
         cnt_q   <= cnt_d;
      end
   end
endmodule

// File: rtl/instr_mem_loader.sv
// rtl/instr_mem_loader.sv - runtime-loadable instruction memory answering datapath fetches one cycle later
module instr_mem_loader
   import instr_mem_loader_pkg::*;
#(
   parameter int ADDR_WIDTH = 8,
   parameter int DATA_WIDTH = 32,
   parameter int DEPTH      = 2**ADDR_WIDTH
) (
   input  logic               clock,
   input  logic               resetGral,
   instr_mem_loader_if.slave  bus
);
   localparam logic [ADDR_WIDTH:0] DEPTH_W = (ADDR_WIDTH+1)'(DEPTH);
   localparam logic [ADDR_WIDTH:0] ONE_W   = (ADDR_WIDTH+1)'(1);

   logic [DATA_WIDTH-1:0] mem [DEPTH];

   state_e                state_q, state_d;
   logic [DATA_WIDTH-1:0] instr_q, instr_d;
   logic                  valid_q, valid_d;
   logic [ADDR_WIDTH:0]   count_q, count_d;
   logic                  ovf_q, ovf_d;
   logic                  part_q, part_d;

   logic                  full;
   logic                  asm_valid;
   logic                  asm_clear;
   logic [31:0]           asm_word;
   logic                  word_done;
   logic                  pending;
   logic [DATA_WIDTH-1:0] rd_data;

   assign full      = (count_q == DEPTH_W);
   // A loadStart edge always wins: the byte on that edge belongs to no load.
   assign asm_valid = (state_q == ST_LOAD) && !bus.loadStart && bus.loadByteValid && !full;
   assign asm_clear = (state_q != ST_LOAD) || bus.loadStart || bus.loadDone;

   instr_word_assembler u_asm (
      .clock      (clock),
      .resetGral  (resetGral),
      .clear      (asm_clear),
      .byte_valid (asm_valid),
      .byte_in    (bus.loadByte),
      .word_out   (asm_word),
      .word_done  (word_done),
      .pending    (pending)
   );

   // wordCount doubles as the write pointer; words beyond it are unreachable stale data.
   always_ff @(posedge clock) begin
      if (word_done)
         mem[count_q[ADDR_WIDTH-1:0]] <= asm_word;
   end

   assign rd_data = ({1'b0, bus.fetchAddr} < count_q) ? mem[bus.fetchAddr] : INSTR_NOP;

   always_comb begin
      state_d = state_q;
      instr_d = instr_q;
      valid_d = valid_q;
      count_d = count_q;
      ovf_d   = ovf_q;
      part_d  = part_q;
      if (bus.loadStart) begin
         state_d = ST_LOAD;
         instr_d = INSTR_NOP;
         valid_d = 1'b0;
         count_d = '0;
         ovf_d   = 1'b0;
         part_d  = 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: ;
            ST_LOAD: begin
               if (bus.loadByteValid && full)
                  ovf_d = 1'b1;
               if (word_done)
                  count_d = count_q + ONE_W;
               if (bus.loadDone) begin
                  state_d = ST_RUN;
                  if (pending)
                     part_d = 1'b1;
               end
            end
            ST_RUN: begin
               if (bus.fetchEn) begin
                  instr_d = rd_data;
                  valid_d = 1'b1;
               end
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clock or posedge resetGral) begin
      if (resetGral) begin
         state_q <= ST_IDLE;
         instr_q <= INSTR_NOP;
         valid_q <= 1'b0;
         count_q <= '0;
         ovf_q   <= 1'b0;
         part_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         instr_q <= instr_d;
         valid_q <= valid_d;
         count_q <= count_d;
         ovf_q   <= ovf_d;
         part_q  <= part_d;
      end
   end

   assign bus.instruction = instr_q;
   assign bus.instrValid  = valid_q;
   assign bus.loadBusy    = (state_q == ST_LOAD);
   assign bus.wordCount   = count_q;
   assign bus.overflowErr = ovf_q;
   assign bus.partialErr  = part_q;
endmodule

// File: tb/tb_instr_mem_loader.sv
// tb/tb_instr_mem_loader.sv - self-checking bench for instr_mem_loader
module tb_instr_mem_loader;
   import instr_mem_loader_pkg::*;

   logic clock = 1'b0;
   logic resetGral;
   always #5 clock = ~clock;

   instr_mem_loader_if #(.ADDR_WIDTH(8), .DATA_WIDTH(32)) bus ();

   instr_mem_loader #(.ADDR_WIDTH(8), .DATA_WIDTH(32), .DEPTH(256)) dut (
      .clock     (clock),
      .resetGral (resetGral),
      .bus       (bus)
   );

   int total  = 0;
   int passed = 0;

   logic [31:0] ref_mem [256];
   int          ref_count;
   bit          ref_ovf;
   bit          ref_part;

   typedef struct {
      logic [7:0]  addr;
      logic        fen;
      logic [31:0] exp_instr;
      logic        exp_valid;
   } vec_t;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   function automatic logic [31:0] ref_fetch(input int addr);
      return (addr < ref_count) ? ref_mem[addr] : INSTR_NOP;
   endfunction

   task automatic load_prog(input logic [7:0] q[$], input bit done_same_edge);
      int n, acc;
      n = q.size();
      bus.loadStart = 1'b1;
      tick();
      bus.loadStart = 1'b0;
      for (int i = 0; i < n; i++) begin
         bus.loadByteValid = 1'b1;
         bus.loadByte      = q[i];
         if (done_same_edge && i == n - 1) bus.loadDone = 1'b1;
         tick();
      end
      bus.loadByteValid = 1'b0;
      if (!(done_same_edge && n > 0)) begin
         bus.loadDone = 1'b1;
         tick();
      end
      bus.loadDone = 1'b0;
      acc       = (n > 1024) ? 1024 : n;
      ref_count = acc / 4;
      for (int w = 0; w < ref_count; w++)
         ref_mem[w] = {q[4*w], q[4*w+1], q[4*w+2], q[4*w+3]};
      ref_ovf  = (n > 1024);
      ref_part = (acc % 4) != 0;
   endtask

   task automatic check_status(input string name);
      check({name, "_count"}, 32'(bus.wordCount), 32'(ref_count));
      check({name, "_ovf"}, 32'(bus.overflowErr), 32'(ref_ovf));
      check({name, "_part"}, 32'(bus.partialErr), 32'(ref_part));
      check({name, "_busy"}, 32'(bus.loadBusy), 32'd0);
   endtask

   task automatic fetch_check(input int addr, input string name);
      bus.fetchEn   = 1'b1;
      bus.fetchAddr = 8'(addr);
      tick();
      bus.fetchEn = 1'b0;
      check({name, "_instr"}, bus.instruction, ref_fetch(addr));
      check({name, "_valid"}, 32'(bus.instrValid), 32'd1);
   endtask

   initial begin
      vec_t        vecs[7];
      logic [7:0]  q[$];
      logic [31:0] held;

      vecs[0] = '{8'd0,   1'b1, 32'h2040028A, 1'b1};
      vecs[1] = '{8'd1,   1'b1, 32'h20410003, 1'b1};
      vecs[2] = '{8'd1,   1'b0, 32'h20410003, 1'b1};
      vecs[3] = '{8'd2,   1'b1, 32'h00201004, 1'b1};
      vecs[4] = '{8'd3,   1'b1, 32'h00000000, 1'b1};
      vecs[5] = '{8'd200, 1'b1, 32'h00000000, 1'b1};
      vecs[6] = '{8'd5,   1'b0, 32'h00000000, 1'b1};

      resetGral         = 1'b1;
      bus.fetchAddr     = '0;
      bus.fetchEn       = 1'b0;
      bus.loadStart     = 1'b0;
      bus.loadByteValid = 1'b0;
      bus.loadByte      = '0;
      bus.loadDone      = 1'b0;
      ref_count = 0; ref_ovf = 0; ref_part = 0;
      #1;
      check("rst_instr", bus.instruction, 32'h0);
      check("rst_valid", 32'(bus.instrValid), 32'd0);
      check_status("rst");
      #13 resetGral = 1'b0;

      // IDLE ignores fetches
      bus.fetchEn = 1'b1; bus.fetchAddr = 8'd0;
      tick();
      bus.fetchEn = 1'b0;
      check("idle_instr", bus.instruction, 32'h0);
      check("idle_valid", 32'(bus.instrValid), 32'd0);

      // three-word program, table-driven fetches
      q = '{8'h20, 8'h40, 8'h02, 8'h8A, 8'h20, 8'h41, 8'h00, 8'h03, 8'h00, 8'h20, 8'h10, 8'h04};
      load_prog(q, 1'b0);
      check_status("load3");
      check("load3_count_const", 32'(bus.wordCount), 32'd3);
      for (int i = 0; i < 7; i++) begin
         bus.fetchEn   = vecs[i].fen;
         bus.fetchAddr = vecs[i].addr;
         tick();
         bus.fetchEn = 1'b0;
         check($sformatf("vec%0d_instr", i), bus.instruction, vecs[i].exp_instr);
         check($sformatf("vec%0d_valid", i), 32'(bus.instrValid), 32'(vecs[i].exp_valid));
      end

      // five bytes then loadDone: one word, partial flagged, cleared by new loadStart
      q = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
      load_prog(q, 1'b0);
      check_status("part");
      check("part_flag", 32'(bus.partialErr), 32'd1);
      fetch_check(0, "part_f0");
      bus.loadStart = 1'b1;
      tick();
      bus.loadStart = 1'b0;
      check("restart_part", 32'(bus.partialErr), 32'd0);
      check("restart_busy", 32'(bus.loadBusy), 32'd1);
      check("restart_count", 32'(bus.wordCount), 32'd0);
      check("restart_valid", 32'(bus.instrValid), 32'd0);
      bus.loadDone = 1'b1;
      tick();
      bus.loadDone = 1'b0;
      ref_count = 0; ref_ovf = 0; ref_part = 0;
      check_status("empty");
      fetch_check(0, "empty_f0");

      // overflow: 1028 bytes into 256 words
      q = {};
      for (int i = 0; i < 1028; i++) q.push_back(8'($urandom));
      load_prog(q, 1'b0);
      check_status("ovf");
      check("ovf_flag", 32'(bus.overflowErr), 32'd1);
      check("ovf_count_const", 32'(bus.wordCount), 32'd256);
      fetch_check(255, "ovf_f255");
      check("ovf_last_word", bus.instruction, {q[1020], q[1021], q[1022], q[1023]});
      fetch_check(0, "ovf_f0");
      for (int i = 0; i < 4; i++) fetch_check($urandom_range(0, 255), "ovf_rand");

      // same-edge 4th byte and loadDone
      q = '{OP_ADDI, 8'h22, 8'h33, 8'h2A};
      load_prog(q, 1'b1);
      check_status("same");
      check("same_count_const", 32'(bus.wordCount), 32'd1);
      fetch_check(0, "same_f0");
      check("same_word", bus.instruction, {OP_ADDI, 8'h22, 8'h33, 8'h2A});

      // async reset mid-load
      bus.loadStart = 1'b1;
      tick();
      bus.loadStart = 1'b0;
      for (int i = 0; i < 6; i++) begin
         bus.loadByteValid = 1'b1;
         bus.loadByte      = 8'(8'hA0 + i);
         tick();
      end
      bus.loadByteValid = 1'b0;
      check("mid_count", 32'(bus.wordCount), 32'd1);
      check("mid_busy", 32'(bus.loadBusy), 32'd1);
      #2 resetGral = 1'b1;
      #1;
      ref_count = 0; ref_ovf = 0; ref_part = 0;
      check_status("arst");
      check("arst_instr", bus.instruction, 32'h0);
      check("arst_valid", 32'(bus.instrValid), 32'd0);
      resetGral = 1'b0;
      load_prog('{}, 1'b0);
      fetch_check(0, "stale_f0");
      fetch_check(1, "stale_f1");

      // randomized programs against the reference model
      for (int r = 0; r < 10; r++) begin
         q = {};
         for (int i = 0; i < int'($urandom_range(0, 40)); i++) q.push_back(8'($urandom));
         load_prog(q, 1'($urandom));
         check_status($sformatf("rnd%0d", r));
         for (int k = 0; k < 6; k++) begin
            if ($urandom_range(0, 3) == 0) begin
               held = bus.instruction;
               bus.fetchAddr = 8'($urandom);
               tick();
               check("rnd_hold", bus.instruction, held);
            end else begin
               fetch_check($urandom_range(0, ref_count + 3), "rnd_fetch");
            end
         end
      end

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
